id_stage_pipe: RTL and testbench

Parametrised instruction-decode stage for the MIPS pipelined CPU.
- Integrates a register file with write-through bypass, immediate extension per opcode class, load-use hazard detection, and an ID/EX pipeline register.
- The pipeline register has valid, stall and flush control.
- Sits between the IF stage (instr/pc in) and EX (ID/EX register out); writeback returns on the wb_* port.

---
 rtl/id_pkg.sv | 45 ++++
 rtl/id_reg_file.sv | 40 ++++
 rtl/id_stage_pipe.sv | 111 +++++++++++
 tb/tb_id_stage_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, instruction field positions,
// the ID/EX payload struct and the immediate-extension helper.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;
  localparam int OPC_W     = 6;
  localparam int FIELD_W   = 5;
  localparam int IMM_W     = 16;

  // Raw instruction fields; operand data lives beside it since its width is per-instance.
  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [FIELD_W-1:0] rs;
    logic [FIELD_W-1:0] rt;
    logic [FIELD_W-1:0] rd;
    logic [IMM_W-1:0]   imm;
    logic [OPC_W-1:0]   funct;
    logic [31:0]        pc;
  } id_ex_t;

  // Produced at the widest legal datapath; callers truncate to DATA_W.
  function automatic logic [63:0] ext_imm(input logic [OPC_W-1:0] op, input logic [IMM_W-1:0] imm);
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: ext_imm = {48'h0, imm};
      OP_LUI:                   ext_imm = {32'h0, imm, 16'h0};
      OP_RTYPE, OP_LW, OP_SW, OP_ADDI: ext_imm = {{48{imm[15]}}, imm};
      default:                  ext_imm = {{48{imm[15]}}, imm};
    endcase
  endfunction

endpackage

// File: rtl/id_reg_file.sv
// Register file: two combinational read ports with write-through bypass, one write port, r0 hardwired to 0.
// Latency: reads 0 cycles, writes visible via bypass same cycle, in the array next cycle.
// Backpressure: none; writes are accepted every cycle.
module id_reg_file #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  localparam int ADDR_W   = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    if (raddr_a != '0) rdata_a = (we && waddr == raddr_a) ? wdata : regs[raddr_a];
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b != '0) rdata_b = (we && waddr == raddr_b) ? wdata : regs[raddr_b];
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: register read, immediate extension, load-use detection, ID/EX register.
// Latency: one cycle instr to ID/EX outputs; a load-use pair costs one bubble.
// Backpressure: id_stall holds IF while EX is not ready or on load-use; flush overrides both.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  localparam int ADDR_W   = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       instr,
  input  logic [31:0]       pc,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              id_stall,
  output logic              id_valid,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [ADDR_W-1:0] rs_addr,
  output logic [ADDR_W-1:0] rt_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] imm_ext,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [31:0]       pc_out
);

  logic [ADDR_W-1:0] rs_idx, rt_idx, lat_rt;
  logic [DATA_W-1:0] rs_rd, rt_rd;
  logic [DATA_W-1:0] rs_q, rt_q;
  logic              valid_q;
  logic              hazard;
  id_ex_t            ex_d, ex_q;

  assign rs_idx = ADDR_W'(instr[RS_LSB +: FIELD_W]);
  assign rt_idx = ADDR_W'(instr[RT_LSB +: FIELD_W]);

  id_reg_file #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT)
  ) u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs_idx),
    .rdata_a (rs_rd),
    .raddr_b (rt_idx),
    .rdata_b (rt_rd)
  );

  always_comb begin
    ex_d        = '0;
    ex_d.opcode = instr[OPC_LSB +: OPC_W];
    ex_d.rs     = instr[RS_LSB +: FIELD_W];
    ex_d.rt     = instr[RT_LSB +: FIELD_W];
    ex_d.rd     = instr[RD_LSB +: FIELD_W];
    ex_d.imm    = instr[IMM_LSB +: IMM_W];
    ex_d.funct  = instr[FUNCT_LSB +: OPC_W];
    ex_d.pc     = pc;
  end

  // Conservative: any rs/rt field match counts, whatever the consumer's format.
  assign lat_rt   = ADDR_W'(ex_q.rt);
  assign hazard   = if_valid & valid_q & (ex_q.opcode == OP_LW) & (lat_rt != '0) &
                    ((rs_idx == lat_rt) | (rt_idx == lat_rt));
  assign id_stall = ~flush & (~ex_ready | hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!ex_ready) begin
      // Held operands track writeback so they are current when EX finally accepts.
      if (wb_we && wb_addr != '0) begin
        if (wb_addr == ADDR_W'(ex_q.rs)) rs_q <= wb_data;
        if (wb_addr == ADDR_W'(ex_q.rt)) rt_q <= wb_data;
      end
    end else if (hazard) begin
      valid_q <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      rs_q    <= rs_rd;
      rt_q    <= rt_rd;
      valid_q <= if_valid;
    end
  end

  assign id_valid = valid_q;
  assign rs_data  = rs_q;
  assign rt_data  = rt_q;
  assign rs_addr  = ADDR_W'(ex_q.rs);
  assign rt_addr  = lat_rt;
  assign rd_addr  = ADDR_W'(ex_q.rd);
  assign imm_ext  = DATA_W'(ext_imm(ex_q.opcode, ex_q.imm));
  assign opcode   = ex_q.opcode;
  assign funct    = ex_q.funct;
  assign pc_out   = ex_q.pc;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed and randomized bench for id_stage_pipe against a behavioural decode-stage model;
// a second 64-bit instance shares the stimulus to cover wide immediate extension.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, wb_we, ex_ready, flush;
  logic [31:0] instr, pc, wb_data;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data_w;

  logic        id_stall, id_valid;
  logic [31:0] rs_data, rt_data, imm_ext, pc_out;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [5:0]  opcode, funct;

  logic        id_stall_w, id_valid_w;
  logic [63:0] rs_data_w, rt_data_w, imm_ext_w;
  logic [31:0] pc_out_w;
  logic [4:0]  rs_addr_w, rt_addr_w, rd_addr_w;
  logic [5:0]  opcode_w, funct_w;

  int tests = 0;
  int fails = 0;

  // Behavioural model state: architectural registers and the latched instruction.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_instr, m_pc, m_rsd, m_rtd;

  always #5 clk = ~clk;
  assign wb_data_w = 64'(wb_data);

  id_stage_pipe #(.DATA_W(32), .REG_COUNT(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr), .pc(pc),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_ready(ex_ready), .flush(flush),
    .id_stall(id_stall), .id_valid(id_valid), .rs_data(rs_data), .rt_data(rt_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .imm_ext(imm_ext),
    .opcode(opcode), .funct(funct), .pc_out(pc_out)
  );

  id_stage_pipe #(.DATA_W(64), .REG_COUNT(32)) dut_w (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr), .pc(pc),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data_w), .ex_ready(ex_ready), .flush(flush),
    .id_stall(id_stall_w), .id_valid(id_valid_w), .rs_data(rs_data_w), .rt_data(rt_data_w),
    .rs_addr(rs_addr_w), .rt_addr(rt_addr_w), .rd_addr(rd_addr_w), .imm_ext(imm_ext_w),
    .opcode(opcode_w), .funct(funct_w), .pc_out(pc_out_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  // Immediate rules expressed arithmetically at 64 bits.
  function automatic logic [63:0] m_ext(input logic [31:0] ins);
    logic [63:0] imm;
    imm = 64'(ins[15:0]);
    case (ins[31:26])
      6'h0C, 6'h0D, 6'h0E: return imm;
      6'h0F:               return imm * 64'd65536;
      default:             return ins[15] ? imm - 64'h10000 : imm;
    endcase
  endfunction

  function automatic bit m_hazard();
    return if_valid && m_valid && m_instr[31:26] == 6'h23 && m_instr[20:16] != 5'd0 &&
           (instr[25:21] == m_instr[20:16] || instr[20:16] == m_instr[20:16]);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0; m_instr = 32'd0; m_pc = 32'd0; m_rsd = 32'd0; m_rtd = 32'd0;
  endtask

  task automatic set_in(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic er, input logic fl);
    if_valid = iv; instr = ins; pc = p; wb_we = we; wb_addr = wa; wb_data = wd;
    ex_ready = er; flush = fl;
  endtask

  task automatic check_outputs();
    chk("id_valid", id_valid, m_valid);
    chk("id_valid_w", id_valid_w, m_valid);
    if (m_valid) begin
      chk("rs_data", rs_data, m_rsd);
      chk("rt_data", rt_data, m_rtd);
      chk("rs_data_w", rs_data_w, 64'(m_rsd));
      chk("rs_addr", rs_addr, m_instr[25:21]);
      chk("rt_addr", rt_addr, m_instr[20:16]);
      chk("rd_addr", rd_addr, m_instr[15:11]);
      chk("opcode", opcode, m_instr[31:26]);
      chk("funct", funct, m_instr[5:0]);
      chk("pc_out", pc_out, m_pc);
      chk("imm_ext", imm_ext, m_ext(m_instr) & 64'hFFFF_FFFF);
      chk("imm_ext_w", imm_ext_w, m_ext(m_instr));
    end
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic step();
    logic        n_valid;
    logic [31:0] n_instr, n_pc, n_rsd, n_rtd;
    bit          hz;
    #1;
    hz = m_hazard();
    chk("id_stall", id_stall, !flush && (!ex_ready || hz));
    n_valid = m_valid; n_instr = m_instr; n_pc = m_pc; n_rsd = m_rsd; n_rtd = m_rtd;
    if (flush) n_valid = 1'b0;
    else if (!ex_ready) begin
      if (wb_we && wb_addr != 5'd0) begin
        if (wb_addr == m_instr[25:21]) n_rsd = wb_data;
        if (wb_addr == m_instr[20:16]) n_rtd = wb_data;
      end
    end else if (hz) n_valid = 1'b0;
    else begin
      n_instr = instr; n_pc = pc; n_valid = if_valid;
      n_rsd = m_read(instr[25:21]); n_rtd = m_read(instr[20:16]);
    end
    if (wb_we && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
    @(posedge clk);
    m_valid = n_valid; m_instr = n_instr; m_pc = n_pc; m_rsd = n_rsd; m_rtd = n_rtd;
    #1;
    check_outputs();
  endtask

  initial begin
    logic [5:0]  ops [8];
    logic [31:0] ins;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h0C;
    ops[4] = 6'h0D; ops[5] = 6'h0E; ops[6] = 6'h0F; ops[7] = 6'h08;

    rst_n = 1'b0;
    set_in(0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 1, 0);
    m_clear();
    #12;
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_stall", id_stall, 1'b0);
    chk("rst_rs_data", rs_data, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Operand read with same-cycle writeback bypass.
    set_in(0, 32'd0, 32'd0, 1, 5'd1, 32'h11, 1, 0); step();
    set_in(1, 32'h002A1820, 32'h100, 1, 5'd10, 32'd1, 1, 0); step();
    chk("t1_valid", id_valid, 1'b1);
    chk("t1_rs", rs_data, 32'h11);
    chk("t1_rt_bypass", rt_data, 32'd1);
    chk("t1_rd", rd_addr, 5'd3);
    chk("t1_funct", funct, 6'h20);
    chk("t1_pc", pc_out, 32'h100);

    // Load-use: exactly one bubble.
    set_in(1, 32'h8C250004, 32'h104, 0, 5'd0, 32'd0, 1, 0); step();
    set_in(1, 32'h00A23020, 32'h108, 0, 5'd0, 32'd0, 1, 0);
    #1 chk("t2_stall", id_stall, 1'b1);
    step();
    chk("t2_bubble", id_valid, 1'b0);
    step();
    chk("t2_add_valid", id_valid, 1'b1);
    chk("t2_add_rs", rs_addr, 5'd5);
    chk("t2_no_stall", id_stall, 1'b0);

    // Immediate extension classes.
    set_in(1, 32'h3402FFFF, 32'h10C, 0, 5'd0, 32'd0, 1, 0); step();
    chk("t3_ori", imm_ext, 32'h0000FFFF);
    set_in(1, 32'h2002FFFF, 32'h110, 0, 5'd0, 32'd0, 1, 0); step();
    chk("t3_addi", imm_ext, 32'hFFFFFFFF);
    chk("t3_addi_w", imm_ext_w, 64'hFFFF_FFFF_FFFF_FFFF);
    set_in(1, 32'h3C041234, 32'h114, 0, 5'd0, 32'd0, 1, 0); step();
    chk("t3_lui", imm_ext, 32'h12340000);
    chk("t3_lui_w", imm_ext_w, 64'h0000_0000_1234_0000);

    // EX backpressure: hold, with held operand refreshed by writeback.
    set_in(1, 32'h002A1820, 32'h200, 0, 5'd0, 32'd0, 1, 0); step();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h00431020, 32'h204, (i == 0), 5'd1, 32'h99, 0, 0);
      #1 chk("t4_stall", id_stall, 1'b1);
      step();
    end
    chk("t4_rs_fresh", rs_data, 32'h99);
    chk("t4_pc_held", pc_out, 32'h200);
    chk("t4_rd_held", rd_addr, 5'd3);

    // Flush beats backpressure; r0 ignores writes and bypass.
    set_in(1, 32'h00431020, 32'h204, 0, 5'd0, 32'd0, 0, 1);
    #1 chk("t5_stall", id_stall, 1'b0);
    step();
    chk("t5_flushed", id_valid, 1'b0);
    set_in(0, 32'd0, 32'd0, 1, 5'd0, 32'hDEAD, 1, 0); step();
    set_in(1, 32'h00001820, 32'h300, 1, 5'd0, 32'hBEEF, 1, 0); step();
    chk("t5_r0_rs", rs_data, 32'd0);
    chk("t5_r0_rt", rt_data, 32'd0);

    // Asynchronous reset between edges wipes the register file and ID/EX.
    set_in(0, 32'd0, 32'd0, 1, 5'd7, 32'd5, 1, 0); step();
    set_in(0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", id_valid, 1'b0);
    chk("t6_async_pc", pc_out, 32'd0);
    chk("t6_async_rs", rs_data, 32'd0);
    m_clear();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    set_in(1, 32'h00E04020, 32'h400, 0, 5'd0, 32'd0, 1, 0); step();
    chk("t6_r7_cleared", rs_data, 32'd0);
    chk("t6_valid", id_valid, 1'b1);

    // Randomized traffic over a small register window to provoke hazards and bypasses.
    for (int n = 0; n < 400; n++) begin
      ins = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 11'($urandom)};
      set_in(($urandom_range(0, 99) < 85), ins, $urandom, ($urandom_range(0, 1) == 1),
             5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 99) < 80),
             ($urandom_range(0, 99) < 10));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
